// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card responder: command decode, R1/R7, init model, CMD17 block reads
module sd_spi_responder #(
  parameter int ADDR_W      = 16,
  parameter int ACMD41_BUSY = 2,
  parameter int NCR_BYTES   = 1,
  parameter int NAC_BYTES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic              cmd_valid,
  output logic [5:0]        cmd_index,
  output logic [31:0]       cmd_arg,
  output logic              card_ready
);

  localparam int BW    = (ACMD41_BUSY > 0) ? $clog2(ACMD41_BUSY + 1) : 1;
  localparam int BLK_W = ADDR_W - 9;

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_NCR, S_RESP, S_NAC, S_DATA, S_CRC} state_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [1:0]        sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, cs_sync_q, cs_sync_d;
  logic              sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [37:0]       cmd_sh_q, cmd_sh_d;
  logic [39:0]       resp_q, resp_d;
  logic [2:0]        resp_last_q, resp_last_d;
  logic              rd_go_q, rd_go_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [5:0]        cmd_index_q, cmd_index_d;
  logic [31:0]       cmd_arg_q, cmd_arg_d;
  logic              idle_q, idle_d, app_q, app_d, card_ready_q, card_ready_d;
  logic [BW-1:0]     busy_q, busy_d;
  logic [9:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        pref_q, pref_d;
  logic              mem_rd_en_q, mem_rd_en_d, rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              sclk_s, mosi_s, cs_s;
  logic              byte_done, load;
  logic [7:0]        rx_byte, nb, r1;
  logic [5:0]        c_idx;
  logic [31:0]       c_arg;
  logic [BLK_W-1:0]  blk;

  assign sclk_s = sclk_sync_q[1];
  assign mosi_s = mosi_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign blk    = cmd_arg_q[BLK_W-1:0];
  assign c_idx  = cmd_sh_q[37:32];
  assign c_arg  = cmd_sh_q[31:0];

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[0], sclk};
    mosi_sync_d  = {mosi_sync_q[0], mosi};
    cs_sync_d    = {cs_sync_q[0], cs_n};
    sclk_prev_d  = sclk_s;
    cs_prev_d    = cs_s;
    bit_cnt_d    = bit_cnt_q;
    rx_sh_d      = rx_sh_q;
    tx_sh_d      = tx_sh_q;
    miso_d       = miso_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_sh_d     = cmd_sh_q;
    resp_d       = resp_q;
    resp_last_d  = resp_last_q;
    rd_go_d      = rd_go_q;
    cmd_valid_d  = 1'b0;
    cmd_index_d  = cmd_index_q;
    cmd_arg_d    = cmd_arg_q;
    idle_d       = idle_q;
    app_d        = app_q;
    card_ready_d = card_ready_q;
    busy_d       = busy_q;
    byte_idx_d   = byte_idx_q;
    crc_d        = crc_q;
    pref_d       = pref_q;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    rd_pend_d    = mem_rd_en_q;
    byte_done    = 1'b0;
    load         = 1'b0;
    rx_byte      = 8'h00;
    nb           = 8'hFF;
    r1           = 8'h00;

    if (rd_pend_q) pref_d = mem_data;

    if (cs_s) begin
      state_d   = S_HUNT;
      bit_cnt_d = 3'd0;
      cnt_d     = 4'd0;
      tx_sh_d   = 8'hFF;
      miso_d    = 1'b1;
    end else begin
      if (sclk_s && !sclk_prev_q) begin
        rx_sh_d   = {rx_sh_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_done = 1'b1;
          rx_byte   = {rx_sh_q, mosi_s};
        end
      end
      // A byte boundary on the falling edge (or the select edge) loads the next outgoing byte
      load = cs_prev_q || (!sclk_s && sclk_prev_q && bit_cnt_q == 3'd0);
      if (!sclk_s && sclk_prev_q && bit_cnt_q != 3'd0) begin
        miso_d  = tx_sh_q[6];
        tx_sh_d = {tx_sh_q[6:0], 1'b1};
      end

      if (byte_done) begin
        if (state_q == S_HUNT && rx_byte[7:6] == 2'b01) begin
          cmd_sh_d = {cmd_sh_q[29:0], rx_byte};
          cnt_d    = 4'd1;
          state_d  = S_CMD;
        end else if (state_q == S_CMD && cnt_q != 4'd5) begin
          cmd_sh_d = {cmd_sh_q[29:0], rx_byte};
          cnt_d    = cnt_q + 4'd1;
        end else if (state_q == S_CMD) begin
          cmd_valid_d = 1'b1;
          cmd_index_d = c_idx;
          cmd_arg_d   = c_arg;
          app_d       = (c_idx == 6'd55);
          rd_go_d     = 1'b0;
          resp_last_d = 3'd0;
          case (c_idx)
            6'd0: begin
              idle_d       = 1'b1;
              card_ready_d = 1'b0;
              busy_d       = '0;
              r1           = 8'h01;
            end
            6'd8, 6'd55: r1 = {7'd0, idle_q};
            6'd41: begin
              if (!app_q)                         r1 = {5'd0, 1'b1, 1'b0, idle_q};
              else if (busy_q < BW'(ACMD41_BUSY)) begin
                busy_d = busy_q + BW'(1);
                r1     = 8'h01;
              end else begin
                idle_d       = 1'b0;
                card_ready_d = 1'b1;
                r1           = 8'h00;
              end
            end
            6'd17: begin
              if (idle_q) r1 = 8'h05;
              else begin
                r1      = 8'h00;
                rd_go_d = 1'b1;
              end
            end
            default: r1 = {5'd0, 1'b1, 1'b0, idle_q};
          endcase
          if (c_idx == 6'd8) begin
            resp_d      = {r1, 16'h0000, 4'h0, c_arg[11:8], c_arg[7:0]};
            resp_last_d = 3'd4;
          end else begin
            resp_d = {r1, 32'hFFFF_FFFF};
          end
          cnt_d   = 4'd0;
          state_d = (NCR_BYTES == 0) ? S_RESP : S_NCR;
        end
      end

      if (load) begin
        case (state_q)
          S_NCR: begin
            if (cnt_q == 4'(NCR_BYTES - 1)) begin
              cnt_d   = 4'd0;
              state_d = S_RESP;
            end else cnt_d = cnt_q + 4'd1;
          end
          S_RESP: begin
            nb     = resp_q[39:32];
            resp_d = {resp_q[31:0], 8'hFF};
            if (cnt_q[2:0] == resp_last_q) begin
              cnt_d   = 4'd0;
              state_d = rd_go_q ? S_NAC : S_HUNT;
            end else cnt_d = cnt_q + 4'd1;
          end
          S_NAC: begin
            if (cnt_q == 4'(NAC_BYTES)) begin
              nb          = 8'hFE;
              cnt_d       = 4'd0;
              state_d     = S_DATA;
              byte_idx_d  = 10'd0;
              crc_d       = 16'h0000;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = {blk, 9'd0};
            end else cnt_d = cnt_q + 4'd1;
          end
          S_DATA: begin
            nb    = pref_q;
            crc_d = crc16_byte(crc_q, pref_q);
            if (byte_idx_q == 10'd511) begin
              byte_idx_d = 10'd0;
              state_d    = S_CRC;
            end else begin
              byte_idx_d  = byte_idx_q + 10'd1;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = {blk, byte_idx_d[8:0]};
            end
          end
          S_CRC: begin
            if (cnt_q == 4'd0) begin
              nb    = crc_q[15:8];
              cnt_d = 4'd1;
            end else begin
              nb      = crc_q[7:0];
              cnt_d   = 4'd0;
              state_d = S_HUNT;
            end
          end
          default: nb = 8'hFF;
        endcase
        tx_sh_d = nb;
        miso_d  = nb[7];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= 2'b00;
      mosi_sync_q  <= 2'b11;
      cs_sync_q    <= 2'b11;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= 3'd0;
      rx_sh_q      <= 7'h7F;
      tx_sh_q      <= 8'hFF;
      miso_q       <= 1'b1;
      state_q      <= S_HUNT;
      cnt_q        <= 4'd0;
      cmd_sh_q     <= '0;
      resp_q       <= '1;
      resp_last_q  <= 3'd0;
      rd_go_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_index_q  <= 6'd0;
      cmd_arg_q    <= 32'd0;
      idle_q       <= 1'b1;
      app_q        <= 1'b0;
      card_ready_q <= 1'b0;
      busy_q       <= '0;
      byte_idx_q   <= 10'd0;
      crc_q        <= 16'h0000;
      pref_q       <= 8'h00;
      mem_rd_en_q  <= 1'b0;
      rd_pend_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sh_q      <= rx_sh_d;
      tx_sh_q      <= tx_sh_d;
      miso_q       <= miso_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_sh_q     <= cmd_sh_d;
      resp_q       <= resp_d;
      resp_last_q  <= resp_last_d;
      rd_go_q      <= rd_go_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_index_q  <= cmd_index_d;
      cmd_arg_q    <= cmd_arg_d;
      idle_q       <= idle_d;
      app_q        <= app_d;
      card_ready_q <= card_ready_d;
      busy_q       <= busy_d;
      byte_idx_q   <= byte_idx_d;
      crc_q        <= crc_d;
      pref_q       <= pref_d;
      mem_rd_en_q  <= mem_rd_en_d;
      rd_pend_q    <= rd_pend_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign miso       = miso_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign cmd_arg    = cmd_arg_q;
  assign card_ready = card_ready_q;

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
SPI-mode SD card responder. It is the card-side end of the SPI link that our SD host controller drives, and it backs a block-read path from an on-chip byte memory. The bench uses it as the card model, and it doubles as an emulated card on the FPGA. It decodes 48-bit command frames, returns R1/R7 responses, models the idle/ready init sequence, and serves CMD17 single-block reads with start token and CRC16.

Parameters:
ADDR_W, 16, width of mem_addr in bits; must be at least 10.
ACMD41_BUSY, 2, number of ACMD41 calls that answer busy (0x01) before the card reports ready (0x00).
NCR_BYTES, 1, number of 0xFF bytes between a command's CRC byte and its R1.
NAC_BYTES, 2, number of 0xFF bytes between the CMD17 R1 and the 0xFE start token.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sclk  in  1  SPI clock from host; mode 0; asynchronous to clk
mosi  in  1  host to card data, MSB first
cs_n  in  1  chip select, active low
miso  out  1  card to host data
mem_addr  out  ADDR_W  byte address = {arg[ADDR_W-10:0], byte_idx[8:0]}
mem_rd_en  out  1  one-cycle read strobe
mem_data  in  8  read data, valid exactly 1 clk after mem_rd_en
cmd_valid  out  1  one-cycle pulse when a complete command frame is decoded
cmd_index  out  6  index of the last decoded command
cmd_arg  out  32  argument of the last decoded command
card_ready  out  1  high once ACMD41 has returned 0x00

Behaviour:
- Synchronisation: sclk, mosi and cs_n each pass through 2-FF synchronisers. Edges are detected on the synchronised sclk. Requires sclk half-period of at least 4 clk.
- Bit timing: sample mosi on each sclk rising edge. Shift miso on each falling edge. Bit7 of a byte is presented on the falling edge after bit0 of the previous byte was sampled; the first byte after cs_n falls presents bit7 immediately.
- miso: 1 whenever cs_n is high, and when no response byte is queued (filler 0xFF).
- Reset values: miso=1, mem_rd_en=0, mem_addr=0, cmd_valid=0, cmd_index=0, cmd_arg=0, card_ready=0. Internally: idle flag=1, app flag=0, busy counter=0, FSM=HUNT.
- cs_n high mid-transfer: FSM returns to HUNT, the bit counter clears, and any response or data burst is abandoned. idle, app and card_ready are kept.
- FSM states:
  - HUNT: wait for a received byte with bits[7:6]=01, then go to CMD.
  - CMD: collect 5 more bytes. The CRC byte is accepted but not checked. Pulse cmd_valid, update cmd_index/cmd_arg, go to NCR.
  - NCR: send NCR_BYTES × 0xFF, then go to RESP.
  - RESP: send the R1 byte, plus the R7 tail if applicable. Then go to HUNT, or to NAC for an accepted CMD17.
  - NAC: send NAC_BYTES × 0xFF, then 0xFE, then go to DATA.
  - DATA: send 512 bytes, then go to CRC.
  - CRC: send the 2-byte CRC16, MSB first, then go to HUNT.
- Bytes arriving on mosi outside HUNT/CMD are ignored. A new start byte is recognised only in HUNT.
- Command decode (R1 bit0 = idle flag at the time of response; bit2 = illegal):
  - CMD0: set idle=1, clear app and card_ready, reset busy counter; R1=0x01.
  - CMD8: R1 followed by 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: set app=1; R1.
  - CMD41 with app=1: if busy counter < ACMD41_BUSY, increment it and send R1=0x01. Otherwise clear idle, set card_ready, and send 0x00.
  - CMD17 with idle=0: R1=0x00, then the data burst.
  - CMD17 with idle=1: R1=0x05, no data.
  - Any other command, or CMD41 with app=0: R1=0x04|idle.
  - app clears after any command other than CMD55.
- Data fetch:
  - Each payload byte is requested (mem_rd_en pulse) on the first clk after the previous byte is loaded into the shift register. For byte 0, the request is made when 0xFE is loaded.
  - mem_data is captured 1 clk later into a prefetch register.
  - byte_idx wraps 511→0 and is not reused.
- CRC16: CCITT polynomial 0x1021, init 0x0000, computed bytewise over the 512 payload bytes as each one is loaded.
- Counters: byte_idx is 10 bits, busy counter is $clog2(ACMD41_BUSY+1) bits and saturates, NCR/NAC counters are 4 bits.

Test Plan:
1. Reset, then frame 40 00 00 00 00 95 followed by FF clocking → 1 byte FF, then 0x01; cmd_valid pulses once with cmd_index=0, cmd_arg=0.
2. Frame 48 00 00 01 AA 87 → FF, 01, 00, 00, 01, AA.
3. Two rounds of 77 00 00 00 00 01 + 69 40 00 00 00 77 → ACMD41 R1 = 01 then 01. Third round → 00 and card_ready=1.
4. Memory loaded with byte i = i[7:0] at block 3; send 51 00 00 00 03 FF → 00, FF, FF, FE, 512 bytes 00..FF twice, then the CRC16 of that payload; mem_addr sequence starts at 0x0600 and ends at 0x07FF.
5. CMD17 after reset with no init → 0x05 and no FE token. CMD24 frame → 0x04 or 0x05 according to idle.
6. Deassert cs_n after data byte 100, reassert, send CMD0 → miso=1 during the gap, no stale data, response 0x01, card_ready cleared.
